// File: rtl/sram_stream_reader_pkg.sv
// Shared defaults, FSM state type and FIFO count-width helper for sram_stream_reader.
package sram_stream_reader_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 128;
  localparam int unsigned ADDR_WIDTH_DEF = 12;
  localparam int unsigned FIFO_DEPTH_DEF = 2;
  localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  // Count must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sram_stream_reader_fifo.sv
// Synchronous FIFO for sram_stream_reader; push into a full FIFO is accepted when a pop
// frees the slot in the same cycle.
module sram_stream_reader_fifo
  import sram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Burst read initiator for a 1-cycle-latency SRAM read port, streaming words out over
// valid/ready. Define SRAM_STREAM_READER_LAST_EN to add the out_last end-of-burst flag.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] radr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef SRAM_STREAM_READER_LAST_EN
  output logic                  out_last,
`endif
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned CntW = cnt_width(FIFO_DEPTH);
`ifdef SRAM_STREAM_READER_LAST_EN
  localparam int unsigned FifoW = DATA_WIDTH + 1;
`else
  localparam int unsigned FifoW = DATA_WIDTH;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q;
  logic                  done_q, done_d;

  logic [CntW-1:0]       fifo_count;
  logic                  fifo_full, fifo_empty;
  logic [FifoW-1:0]      fifo_wdata, fifo_rdata;
  logic                  pop, credit_ok;
  logic [CntW:0]         occ;

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign radr      = addr_q;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_rdata[DATA_WIDTH-1:0];

  // Occupancy after this cycle's pop: stored words plus the word already on its way from SRAM.
  always_comb begin
    occ       = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
    credit_ok = !(fifo_full && !pop) && (occ < (CntW + 1)'(FIFO_DEPTH));
    re        = (state_q == StIssue) && (remaining_q != '0) && credit_ok;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d      = cmd_addr;
          remaining_d = cmd_len;
          if (cmd_len == '0) done_d = 1'b1;
          else               state_d = StIssue;
        end
      end
      StIssue: begin
        if (re) begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (ADDR_WIDTH + 1)'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // The final word leaves the FIFO this cycle and nothing else is pending.
        if (pop && (fifo_count == CntW'(1)) && !inflight_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= re;
      done_q      <= done_d;
    end
  end

`ifdef SRAM_STREAM_READER_LAST_EN
  logic last_inflight_q;

  always_ff @(posedge clk) begin
    if (rst) last_inflight_q <= 1'b0;
    else     last_inflight_q <= re && (remaining_q == (ADDR_WIDTH + 1)'(1));
  end

  assign fifo_wdata = {last_inflight_q, q};
  assign out_last   = fifo_rdata[DATA_WIDTH];
`else
  assign fifo_wdata = q;
`endif

  sram_stream_reader_fifo #(
    .WIDTH (FifoW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader with a behavioural 1-cycle SRAM read port
// preloaded as mem[a] = {4{a}}.
module tb_sram_stream_reader;

  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 12;
  localparam int          DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          re;
  logic [AW-1:0] radr;
  logic [DW-1:0] q = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          done;
  logic          busy;
`ifdef SRAM_STREAM_READER_LAST_EN
  logic          out_last;
`endif

  sram_stream_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .re        (re),
    .radr      (radr),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SRAM_STREAM_READER_LAST_EN
    .out_last  (out_last),
`endif
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {20'd0, a};
    return {4{w}};
  endfunction

  // SRAM wrapper read port: data one cycle after re.
  always @(posedge clk) if (re) q <= mem_word(radr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] radr_q[$];
  int            tb_occ = 0;
  int            re_cnt = 0;
  int            pop_cnt = 0;
  int            done_cnt = 0;
  int            last_hs_cyc = 0;
  int            first_valid_cyc = 0;
  int            acc_cyc = 0;
  bit            saw_valid = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Monitor: scoreboard pops, radr order, credit rule and stall stability.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      tb_occ     = 0;
      prev_stall = 1'b0;
    end else begin
      logic [DW:0] e;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (re) begin
        re_cnt++;
        check("credit", ((tb_occ - ((out_valid && out_ready) ? 1 : 0)) < DEPTH), 1);
        if (radr_q.size() == 0) check("radr_extra", 1, 0);
        else                    check("radr", radr, radr_q.pop_front());
      end
      if (out_valid && !saw_valid) begin
        saw_valid       = 1'b1;
        first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("data_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", out_data, e[DW-1:0]);
`ifdef SRAM_STREAM_READER_LAST_EN
          check("last", out_last, e[DW]);
`endif
        end
      end
      if (done) done_cnt++;
      tb_occ     = tb_occ + (re ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input logic [AW:0] n);
    for (int i = 0; i < int'(n); i++) begin
      logic [AW-1:0] ai;
      ai = a + AW'(i);
      radr_q.push_back(ai);
      exp_q.push_back({(i == int'(n) - 1), mem_word(ai)});
    end
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW:0] n);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
    end else begin
      push_exp(a, n);
      acc_cyc = cyc;
      if (n == '0) last_hs_cyc = cyc;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, got, 1);
    if (got) check({tag, "_done_lat"}, cyc - last_hs_cyc, 1);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_single"}, done, 0);
    check({tag, "_exp_empty"}, exp_q.size(), 0);
    check({tag, "_radr_empty"}, radr_q.size(), 0);
  endtask

  initial begin
    int p0, d0, r0, low_cnt, npop;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready_after", cmd_ready, 1);
    check("rst_re", re, 0);
    check("rst_radr", radr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);

    // 1: basic burst, full throughput
    out_ready = 1'b1;
    saw_valid = 1'b0;
    p0 = pop_cnt;
    send_cmd(12'h010, 13'd4);
    wait_done("t1", 40);
    check("t1_first_valid_lat", first_valid_cyc - acc_cyc, 3);
    check("t1_consecutive", last_hs_cyc - first_valid_cyc, 3);
    check("t1_count", pop_cnt - p0, 4);

    // 2: address wrap
    send_cmd(12'hFFE, 13'd4);
    wait_done("t2", 40);

    // 3: backpressure 1,0,0 pattern
    p0 = pop_cnt;
    send_cmd(12'h100, 13'd8);
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        out_ready = ((k % 3) == 0);
        @(negedge clk);
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      check("t3_done_seen", got, 1);
      if (got) check("t3_done_lat", cyc - last_hs_cyc, 1);
    end
    check("t3_count", pop_cnt - p0, 8);
    check("t3_exp_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // 4: empty burst
    r0 = re_cnt;
    d0 = done_cnt;
    low_cnt = 0;
    send_cmd(12'h050, 13'd0);
    wait_done("t4", 10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!cmd_ready) low_cnt++;
    end
    check("t4_no_re", re_cnt - r0, 0);
    check("t4_done_once", done_cnt - d0, 1);
    check("t4_cmd_ready_high", low_cnt, 0);

    // 5: reset mid-burst
    send_cmd(12'h300, 13'd16);
    npop = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) npop++;
      if (npop == 6) break;
    end
    check("t5_reached_6th", npop, 6);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    radr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    check("t5_re", re, 0);
    check("t5_busy", busy, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    p0 = pop_cnt;
    send_cmd(12'h200, 13'd2);
    wait_done("t5b", 40);
    check("t5b_count", pop_cnt - p0, 2);

    // 6: cmd_valid held high across two bursts
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = 12'h400;
    cmd_len   = 13'd3;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check("t6_first_accept", cmd_ready, 1);
    push_exp(12'h400, 13'd3);
    @(posedge clk); #1;
    cmd_addr = 12'h410;
    cmd_len  = 13'd2;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check("t6_second_accept", cmd_ready, 1);
    check("t6_first_drained", exp_q.size(), 0);
    check("t6_first_done", done, 1);
    check("t6_idle_at_accept", busy, 0);
    push_exp(12'h410, 13'd2);
    last_hs_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done("t6", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
